bist_pattern_generator: RTL
===========================

Name: bist_pattern_generator

Overview:
- Built-in self-test stimulus source for the gray/Sobel pipeline input.
- Emits a deterministic pseudo-random stream of 24-bit pixels from a 24-bit LFSR, using a valid/ready handshake into the pipeline input.
- The pipeline output is compressed by the existing signature analyzer. A fixed seed and pixel count give a golden signature for production test.
- Complements the compressor: this block drives the pipeline input, the analyzer compacts its output.

Parameters:
- PIXEL_WIDTH_IN, 24, width of generated pixel (equals MAX_PIXEL_BITS).
- COUNT_WIDTH, 16, width of pixel-count input and counter.
- DEFAULT_SEED, 24'h000001, seed substituted when seed_i is zero.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- nreset_i  in  1  reset, synchronous and active-low.
- start_i  in  1  pulse: load seed, clear counter, begin run.
- clear_i  in  1  abort/return to IDLE; has priority over start_i.
- seed_i  in  PIXEL_WIDTH_IN  LFSR seed, sampled on accepted start.
- num_pixels_i  in  COUNT_WIDTH  pixels to emit, sampled on accepted start.
- rdy_i  in  1  downstream ready.
- valid_o  out  1  pixel_o valid.
- pixel_o  out  PIXEL_WIDTH_IN  generated pixel.
- busy_o  out  1  high in RUN.
- done_o  out  1  level, high in DONE.
- count_o  out  COUNT_WIDTH  pixels accepted so far this run.

Behaviour:
- Reset (nreset_i low at a clock edge): state IDLE, lfsr=0, count=0, valid_o=0, busy_o=0, done_o=0, pixel_o=0.
- LFSR: Fibonacci, left shift, taps x^24+x^23+x^22+x^17+1.
  - next = {lfsr[22:0], lfsr[23]^lfsr[22]^lfsr[21]^lfsr[16]}.
  - Never holds zero during RUN: seed_i==0 loads DEFAULT_SEED.
- States:
  - IDLE:
    - valid_o=0.
    - On start_i & !clear_i: lfsr<=seed (or DEFAULT_SEED), count<=0, latch num_pixels.
    - If latched count is 0, go to DONE; otherwise go to RUN.
  - RUN:
    - valid_o=1, pixel_o=lfsr, busy_o=1.
    - Transfer when valid_o && rdy_i: lfsr<=next, count<=count+1.
    - If the transfer is the last pixel (count==N-1), go to DONE in the same edge.
    - No transfer: pixel_o and count hold. pixel_o never changes while valid_o && !rdy_i.
  - DONE:
    - done_o=1, valid_o=0; count_o holds N, lfsr holds.
    - start_i: behaves as in IDLE (restart directly).
    - clear_i: go to IDLE.
- Latency: first valid_o one cycle after start_i is sampled. Back-to-back transfers at 1 pixel/cycle while rdy_i is high. N pixels take N cycles at full rate.
- clear_i in any state: next state IDLE, valid_o=0 next cycle, count<=0, lfsr<=0. A pending un-accepted pixel is dropped.
- start_i during RUN: ignored.
- clear_i and start_i in the same cycle: clear wins.
- Counter does not wrap: max run is 2^COUNT_WIDTH-1 pixels.
- Synchronous reset mid-run: identical to power-on reset at that edge.

Optional Feature:
- Macro BIST_PATTERN_RAMP_EN.
- Defined:
  - Extra input port mode_i (1 bit), sampled on accepted start.
  - mode_i=1: pattern is a ramp. pixel starts at seed_i (zero allowed) and advances by +1 per transfer, wrapping 24'hFFFFFF->0.
  - mode_i=0: LFSR behaviour as above.
- Undefined: port absent, LFSR only; no ramp logic synthesised.

Decomposition:
- Shared package/parameters header:
  - PIXEL_WIDTH_IN.
  - LFSR tap constants.
  - DEFAULT_SEED.
  - State typedef enum {IDLE, RUN, DONE}.
  - Mode typedef under the macro.
- One sub-module, bist_lfsr_step: combinational next-state of the 24-bit LFSR. It is reusable by the testbench model and by future on-chip checkers.
- FSM, counter, and handshake stay in bist_pattern_generator.

Test Plan:
- Seed 24'h000001, N=4, rdy_i=1: pixels 000001, 000002, 000004, 000008 on four consecutive cycles. done_o rises the cycle after the 4th; count_o=4.
- Seed 24'h800000, N=2: pixels 800000, 000001. Seed 0, N=1: pixel 000001 (DEFAULT_SEED substitution).
- Seed 1, N=3, rdy_i low for 3 cycles after the first valid: pixel_o held at 000001, count_o=0 throughout. Stream resumes 000002, 000004.
- clear_i asserted after 2 transfers of N=10: valid_o=0 and state IDLE next cycle, count_o=0. A new start with seed 1 replays from 000001.
- N=0 start: done_o=1 next cycle, valid_o never asserted. start_i and clear_i in the same cycle from IDLE: stays IDLE.
- With BIST_PATTERN_RAMP_EN, mode_i=1, seed 24'hFFFFFE, N=3: pixels FFFFFE, FFFFFF, 000000. nreset_i low mid-run: all outputs 0 at the next edge.

Source files
------------

// File: rtl/bist_pattern_generator_pkg.sv
// Shared constants and types for the BIST pattern generator.
// Optional ramp pattern is enabled with the BIST_PATTERN_RAMP_EN macro.
package bist_pattern_generator_pkg;

  // Pixel width matches the widest pixel the gray/Sobel pipeline accepts.
  localparam int PIXEL_WIDTH_IN = 24;
  localparam int COUNT_WIDTH    = 16;

  // Seed used whenever the supplied seed would lock the LFSR at zero.
  localparam logic [PIXEL_WIDTH_IN-1:0] DEFAULT_SEED = 24'h000001;

  // Polynomial x^24 + x^23 + x^22 + x^17 + 1 expressed as register taps.
  localparam int LFSR_TAP_A = 23;
  localparam int LFSR_TAP_B = 22;
  localparam int LFSR_TAP_C = 21;
  localparam int LFSR_TAP_D = 16;
  localparam logic [PIXEL_WIDTH_IN-1:0] LFSR_TAP_MASK = 24'hE10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef BIST_PATTERN_RAMP_EN
  typedef enum logic {
    MODE_LFSR = 1'b0,
    MODE_RAMP = 1'b1
  } mode_t;
`endif

  // Feedback bit is the XOR (parity) of the tapped register bits.
  function automatic logic lfsr_feedback(input logic [PIXEL_WIDTH_IN-1:0] value);
    return ^(value & LFSR_TAP_MASK);
  endfunction

endpackage

// File: rtl/bist_lfsr_step.sv
// Combinational next-state of the 24-bit Fibonacci LFSR (left shift).
// Kept separate so checkers can reuse the exact same step function.
module bist_lfsr_step
  import bist_pattern_generator_pkg::*;
(
  input  logic [PIXEL_WIDTH_IN-1:0] lfsr_cur,
  output logic [PIXEL_WIDTH_IN-1:0] lfsr_next
);

  // Shift left and insert the tap parity into bit 0.
  always_comb begin
    lfsr_next = {lfsr_cur[PIXEL_WIDTH_IN-2:0], lfsr_feedback(lfsr_cur)};
  end

endmodule

// File: rtl/bist_pattern_generator.sv
// BIST stimulus source: streams a deterministic pixel sequence over a
// valid/ready handshake into the pipeline input. A run is started with
// start_i, emits num_pixels_i pixels and then parks in DONE.
// Optional macro BIST_PATTERN_RAMP_EN adds mode_i and a +1 ramp pattern.
module bist_pattern_generator
  import bist_pattern_generator_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [PIXEL_WIDTH_IN-1:0] seed_i,
  input  logic [COUNT_WIDTH-1:0]    num_pixels_i,
  input  logic                      rdy_i,
`ifdef BIST_PATTERN_RAMP_EN
  input  logic                      mode_i,
`endif
  output logic                      valid_o,
  output logic [PIXEL_WIDTH_IN-1:0] pixel_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [COUNT_WIDTH-1:0]    count_o
);

  state_t                    state_r;
  logic [PIXEL_WIDTH_IN-1:0] lfsr_r;
  logic [COUNT_WIDTH-1:0]    count_r;
  logic [COUNT_WIDTH-1:0]    npix_r;
  logic                      valid_r;
  logic                      busy_r;
  logic                      done_r;

  logic [PIXEL_WIDTH_IN-1:0] lfsr_next_s;
  logic [PIXEL_WIDTH_IN-1:0] pat_next_s;
  logic [PIXEL_WIDTH_IN-1:0] load_value_s;
  logic                      last_s;
  logic                      xfer_s;

`ifdef BIST_PATTERN_RAMP_EN
  mode_t                     mode_r;
`endif

  bist_lfsr_step u_lfsr_step (
    .lfsr_cur  (lfsr_r),
    .lfsr_next (lfsr_next_s)
  );

  // Select the next pattern word: LFSR step, or +1 when a ramp run is active.
  always_comb begin
    pat_next_s = lfsr_next_s;
`ifdef BIST_PATTERN_RAMP_EN
    if (mode_r == MODE_RAMP) begin
      pat_next_s = lfsr_r + 24'd1;
    end else begin
      pat_next_s = lfsr_next_s;
    end
`endif
  end

  // Value loaded on start: a zero seed would stall the LFSR, so it is replaced;
  // ramp runs are allowed to start from zero.
  always_comb begin
    if (seed_i == {PIXEL_WIDTH_IN{1'b0}}) begin
      load_value_s = DEFAULT_SEED;
    end else begin
      load_value_s = seed_i;
    end
`ifdef BIST_PATTERN_RAMP_EN
    if (mode_i == 1'b1) begin
      load_value_s = seed_i;
    end else begin
      load_value_s = (seed_i == {PIXEL_WIDTH_IN{1'b0}}) ? DEFAULT_SEED : seed_i;
    end
`endif
  end

  // A transfer happens only while the pixel is offered; the last one ends the run.
  always_comb begin
    xfer_s = valid_r & rdy_i;
    last_s = (count_r == (npix_r - 16'd1));
  end

  // Run-control FSM with counter, pattern register and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_r <= IDLE;
      lfsr_r  <= {PIXEL_WIDTH_IN{1'b0}};
      count_r <= {COUNT_WIDTH{1'b0}};
      npix_r  <= {COUNT_WIDTH{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef BIST_PATTERN_RAMP_EN
      mode_r  <= MODE_LFSR;
`endif
    end else if (clear_i) begin
      // Abort from any state; an offered but unaccepted pixel is dropped.
      state_r <= IDLE;
      lfsr_r  <= {PIXEL_WIDTH_IN{1'b0}};
      count_r <= {COUNT_WIDTH{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_i) begin
            lfsr_r  <= load_value_s;
            count_r <= {COUNT_WIDTH{1'b0}};
            npix_r  <= num_pixels_i;
`ifdef BIST_PATTERN_RAMP_EN
            mode_r  <= mode_i ? MODE_RAMP : MODE_LFSR;
`endif
            if (num_pixels_i == {COUNT_WIDTH{1'b0}}) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
              valid_r <= 1'b1;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          // start_i is ignored here; only the handshake advances the run.
          if (xfer_s) begin
            lfsr_r  <= pat_next_s;
            count_r <= count_r + 16'd1;
            if (last_s) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          lfsr_r  <= {PIXEL_WIDTH_IN{1'b0}};
          count_r <= {COUNT_WIDTH{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o = valid_r;
  assign pixel_o = lfsr_r;
  assign busy_o  = busy_r;
  assign done_o  = done_r;
  assign count_o = count_r;

endmodule
